// File: rtl/md_rx_arbiter_pkg.sv
// Shared MD arbiter types and width helpers, also used by the aligner and its checkers.
package md_rx_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    function automatic int bus_bytes(input int data_width);
        return data_width / 8;
    endfunction

    // A single-byte bus still carries a 1-bit offset field.
    function automatic int offset_w(input int data_width);
        return ($clog2(bus_bytes(data_width)) < 1) ? 1 : $clog2(bus_bytes(data_width));
    endfunction

    function automatic int size_w(input int data_width);
        return $clog2(bus_bytes(data_width)) + 1;
    endfunction

    function automatic int id_w(input int num_req);
        return $clog2(num_req);
    endfunction

endpackage

// File: rtl/md_rx_arbiter_rr_picker.sv
// Combinational round-robin find-first: first set req bit at ptr, ptr+1, ... mod NUM_REQ.
module md_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    int cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/md_rx_arbiter.sv
// Round-robin arbiter sharing the aligner MD RX port between NUM_REQ requesters;
// the grant is held until the MD handshake completes.
module md_rx_arbiter
    import md_rx_arbiter_pkg::*;
#(
    parameter int  ALGN_DATA_WIDTH = 32,
    parameter int  NUM_REQ         = 4,
    localparam int OFFSET_W        = offset_w(ALGN_DATA_WIDTH),
    localparam int SIZE_W          = size_w(ALGN_DATA_WIDTH),
    localparam int ID_W            = id_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ALGN_DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*OFFSET_W-1:0]   req_offset,
    input  logic [NUM_REQ*SIZE_W-1:0]     req_size,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_err,
    output logic                          md_rx_valid,
    output logic [ALGN_DATA_WIDTH-1:0]    md_rx_data,
    output logic [OFFSET_W-1:0]           md_rx_offset,
    output logic [SIZE_W-1:0]             md_rx_size,
    input  logic                          md_rx_ready,
    input  logic                          md_rx_err,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          protocol_err
);

    // Handshake: a beat transfers on a cycle where md_rx_valid && md_rx_ready;
    // the requester must hold valid and fields stable until then, ready may toggle freely.

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            perr_q, perr_d;
    logic [ID_W-1:0] pick_idx;
    logic            pick_found;
    logic            granted;
    logic            cur_valid;
    logic [ID_W-1:0] next_ptr;

    md_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign granted   = (state_q == GRANTED);
    assign cur_valid = req_valid[grant_q];
    assign next_ptr  = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            perr_q   <= perr_d;
        end
    end

    // A dropped valid ends the grant exactly like a handshake, but is flagged.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        perr_d   = perr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (cur_valid && md_rx_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (!cur_valid) begin
                    perr_d   = 1'b1;
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        md_rx_valid  = granted & cur_valid;
        md_rx_data   = '0;
        md_rx_offset = '0;
        md_rx_size   = '0;
        req_ready    = '0;
        req_err      = '0;
        if (granted) begin
            md_rx_data         = req_data[grant_q*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
            md_rx_offset       = req_offset[grant_q*OFFSET_W +: OFFSET_W];
            md_rx_size         = req_size[grant_q*SIZE_W +: SIZE_W];
            req_ready[grant_q] = md_rx_ready;
            req_err[grant_q]   = md_rx_err & md_rx_ready & cur_valid;
        end
    end

    assign grant_id     = grant_q;
    assign busy         = granted;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_md_rx_arbiter.sv
// Self-checking bench for md_rx_arbiter: vector table plus hand-written corner sequences,
// with a scoreboard checking every transferred beat.
module tb_md_rx_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int OW  = 2;
    localparam int SW  = 3;
    localparam int IW  = 2;
    localparam int EW  = IW + SW + OW + W;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_data;
    logic [N*OW-1:0]   req_offset;
    logic [N*SW-1:0]   req_size;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_err;
    logic              md_rx_valid;
    logic [W-1:0]      md_rx_data;
    logic [OW-1:0]     md_rx_offset;
    logic [SW-1:0]     md_rx_size;
    logic              md_rx_ready;
    logic              md_rx_err;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic              protocol_err;

    logic [W-1:0]      d_arr [N];
    logic [OW-1:0]     o_arr [N];
    logic [SW-1:0]     s_arr [N];

    logic [EW-1:0]     exp_q [$];
    int                pass_cnt;
    int                total_cnt;

    typedef struct {
        logic [3:0] rv;
        logic       rdy;
        logic       err;
        logic       ev;
        logic [3:0] erdy;
        logic [3:0] eerr;
        logic [1:0] egnt;
        logic       ebusy;
        logic       eperr;
    } vec_t;

    vec_t vecs [11];

    md_rx_arbiter #(
        .ALGN_DATA_WIDTH (W),
        .NUM_REQ         (N)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_offset   (req_offset),
        .req_size     (req_size),
        .req_ready    (req_ready),
        .req_err      (req_err),
        .md_rx_valid  (md_rx_valid),
        .md_rx_data   (md_rx_data),
        .md_rx_offset (md_rx_offset),
        .md_rx_size   (md_rx_size),
        .md_rx_ready  (md_rx_ready),
        .md_rx_err    (md_rx_err),
        .grant_id     (grant_id),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data   = '0;
        req_offset = '0;
        req_size   = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W]    = d_arr[i];
            req_offset[i*OW +: OW] = o_arr[i];
            req_size[i*SW +: SW]   = s_arr[i];
        end
    end

    // driver / check tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            d_arr[i] = $urandom;
            o_arr[i] = OW'($urandom_range(0, 3));
            s_arr[i] = SW'($urandom_range(0, 4));
        end
    endtask

    task automatic expect_beat(input logic [1:0] id);
        exp_q.push_back({id, s_arr[id], o_arr[id], d_arr[id]});
    endtask

    task automatic drive(input logic [3:0] rv, input logic rdy, input logic err);
        req_valid   = rv;
        md_rx_ready = rdy;
        md_rx_err   = err;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: pop one expected beat per observed handshake
    always @(negedge clk) begin
        if (!rst && md_rx_valid && md_rx_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", 64'(grant_id), 64'hFF);
            end else begin
                check("sb_beat", 64'({grant_id, md_rx_size, md_rx_offset, md_rx_data}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1;
        drive(4'b0000, 1'b0, 1'b0);
        rand_fields();

        vecs[0]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0};
        vecs[4]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[5]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        vecs[6]  = '{4'b1000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[8]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
        vecs[9]  = '{4'b1000, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0};
        vecs[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #4;
        check("rst_valid", 64'(md_rx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_perr", 64'(protocol_err), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        next_cycle();
        rst = 1'b0;

        // single transfer and error forwarding
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rv, vecs[i].rdy, vecs[i].err);
            rand_fields();
            if (vecs[i].ev && vecs[i].rdy) expect_beat(vecs[i].egnt);
            #3;
            check("vec_valid", 64'(md_rx_valid), 64'(vecs[i].ev));
            check("vec_ready", 64'(req_ready), 64'(vecs[i].erdy));
            check("vec_err", 64'(req_err), 64'(vecs[i].eerr));
            check("vec_grant", 64'(grant_id), 64'(vecs[i].egnt));
            check("vec_busy", 64'(busy), 64'(vecs[i].ebusy));
            check("vec_perr", 64'(protocol_err), 64'(vecs[i].eperr));
            next_cycle();
        end

        // fairness: all requesting, ready always high -> 0,1,2,3,0
        for (int k = 0; k < 10; k++) begin
            logic [1:0] seq;
            logic [3:0] onehot;
            seq    = 2'((k - 1) / 2);
            onehot = 4'b0001 << seq;
            drive(4'b1111, 1'b1, 1'b0);
            rand_fields();
            if (k % 2 == 1) expect_beat(seq);
            #3;
            check("fair_busy", 64'(busy), 64'(k % 2));
            if (k % 2 == 1) begin
                check("fair_grant", 64'(grant_id), 64'(seq));
                check("fair_ready", 64'(req_ready), 64'(onehot));
            end
            next_cycle();
        end

        // lock: grant to 2 held while requester 0 waits
        drive(4'b0100, 1'b0, 1'b0);
        rand_fields();
        #3;
        check("lock_idle", 64'(busy), 64'd0);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0101, 1'b0, 1'b0);
            rand_fields();
            #3;
            check("lock_grant", 64'(grant_id), 64'd2);
            check("lock_valid", 64'(md_rx_valid), 64'd1);
            check("lock_data", 64'(md_rx_data), 64'(d_arr[2]));
            check("lock_offset", 64'(md_rx_offset), 64'(o_arr[2]));
            check("lock_size", 64'(md_rx_size), 64'(s_arr[2]));
            next_cycle();
        end
        drive(4'b0101, 1'b1, 1'b0);
        expect_beat(2'd2);
        #3;
        check("lock_hs_ready", 64'(req_ready), 64'b0100);
        next_cycle();
        drive(4'b0001, 1'b0, 1'b0);
        #3;
        check("lock_bubble", 64'(busy), 64'd0);
        next_cycle();
        drive(4'b0001, 1'b1, 1'b0);
        expect_beat(2'd0);
        #3;
        check("lock_next_grant", 64'(grant_id), 64'd0);
        next_cycle();

        // violation: requester 1 drops valid while granted
        drive(4'b0010, 1'b0, 1'b0);
        #3;
        next_cycle();
        drive(4'b0010, 1'b0, 1'b0);
        #3;
        check("viol_grant", 64'(grant_id), 64'd1);
        check("viol_data", 64'(md_rx_data), 64'(d_arr[1]));
        next_cycle();
        drive(4'b0000, 1'b0, 1'b0);
        #3;
        check("viol_drop_valid", 64'(md_rx_valid), 64'd0);
        check("viol_perr_pre", 64'(protocol_err), 64'd0);
        next_cycle();
        drive(4'b0110, 1'b0, 1'b0);
        #3;
        check("viol_perr", 64'(protocol_err), 64'd1);
        check("viol_idle", 64'(busy), 64'd0);
        next_cycle();
        drive(4'b0110, 1'b1, 1'b0);
        expect_beat(2'd2);
        #3;
        check("viol_next_grant", 64'(grant_id), 64'd2);
        next_cycle();
        drive(4'b0000, 1'b0, 1'b0);
        #3;
        check("viol_perr_sticky", 64'(protocol_err), 64'd1);
        next_cycle();

        // reset mid-grant
        drive(4'b0001, 1'b0, 1'b0);
        #3;
        next_cycle();
        #3;
        check("mid_grant_valid", 64'(md_rx_valid), 64'd1);
        rst = 1'b1;
        md_rx_ready = 1'b1;
        #1;
        check("mid_rst_valid", 64'(md_rx_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_data", 64'(md_rx_data), 64'd0);
        check("mid_rst_perr", 64'(protocol_err), 64'd0);
        next_cycle();
        rst = 1'b0;
        drive(4'b1111, 1'b0, 1'b0);
        #3;
        check("post_rst_idle", 64'(busy), 64'd0);
        next_cycle();
        drive(4'b1111, 1'b1, 1'b0);
        expect_beat(2'd0);
        #3;
        check("post_rst_grant", 64'(grant_id), 64'd0);
        next_cycle();
        drive(4'b0000, 1'b0, 1'b0);
        #3;
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
